// File: rtl/conv3x3_pipe.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_pipe
// Purpose  : 3x3 RGB convolution over a streamed column window, latency 3.
//            Optional macro CONV_ABS_EN: sobel kernels output |acc|.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_pipe #(
    parameter int         R_W         = 5,
    parameter int         G_W         = 6,
    parameter int         B_W         = 5,
    parameter int         H_W         = 11,
    parameter int         V_W         = 10,
    parameter logic [2:0] KERNEL_INIT = 3'd0,
    localparam int        PIX_W       = R_W + G_W + B_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [2:0][PIX_W-1:0] data_in,
    input  logic [H_W-1:0]        hcount_in,
    input  logic [V_W-1:0]        vcount_in,
    input  logic                  data_valid_in,
    input  logic [2:0]            kernel_sel_in,
    output logic [PIX_W-1:0]      line_out,
    output logic                  data_valid_out,
    output logic [H_W-1:0]        hcount_out,
    output logic [V_W-1:0]        vcount_out
);

    logic [2:0][PIX_W-1:0] r_win_l;
    logic [2:0][PIX_W-1:0] r_win_c;
    logic [2:0][PIX_W-1:0] r_win_r;
    logic                  r_vld1;
    logic                  r_vld2;
    logic [H_W-1:0]        r_hc1;
    logic [H_W-1:0]        r_hc2;
    logic [V_W-1:0]        r_vc1;
    logic [V_W-1:0]        r_vc2;
    logic [2:0]            r_kern;
    logic [2:0]            r_kern2;
    wire  [PIX_W-1:0]      w_pix;

    // Stage 1: column window; a line start replicates the edge column.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_win_l <= '0;
            r_win_c <= '0;
            r_win_r <= '0;
            r_vld1  <= 1'b0;
            r_hc1   <= '0;
            r_vc1   <= '0;
            r_kern  <= KERNEL_INIT;
        end else begin
            r_vld1 <= data_valid_in;
            if (data_valid_in) begin
                r_hc1   <= hcount_in;
                r_vc1   <= vcount_in;
                r_win_r <= data_in;
                if (hcount_in == '0) begin
                    r_win_l <= data_in;
                    r_win_c <= data_in;
                end else begin
                    r_win_l <= r_win_c;
                    r_win_c <= r_win_r;
                end
                if (hcount_in == '0 && vcount_in == '0) begin
                    r_kern <= kernel_sel_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vld2  <= 1'b0;
            r_hc2   <= '0;
            r_vc2   <= '0;
            r_kern2 <= '0;
        end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_hc2   <= r_hc1;
                r_vc2   <= r_vc1;
                r_kern2 <= r_kern;
            end
        end
    end

    for (genvar gc = 0; gc < 3; gc++) begin : g_chan
        localparam int c_w   = (gc == 0) ? R_W : (gc == 1) ? G_W : B_W;
        localparam int c_lsb = (gc == 0) ? G_W + B_W : (gc == 1) ? B_W : 0;
        localparam int c_aw  = c_w + 6;

        // w_p[col][row]: col 0=left, 2=right; row 0=top, 2=bottom
        logic signed [c_aw-1:0] w_p [3][3];
        logic signed [c_aw-1:0] w_sum;
        logic signed [c_aw-1:0] r_acc;
        logic signed [c_aw-1:0] w_mag;
        logic signed [c_aw-1:0] w_shf;
        logic        [c_w-1:0]  w_res;

        always_comb begin
            for (int r = 0; r < 3; r++) begin
                w_p[0][r] = $signed({6'd0, r_win_l[r][c_lsb +: c_w]});
                w_p[1][r] = $signed({6'd0, r_win_c[r][c_lsb +: c_w]});
                w_p[2][r] = $signed({6'd0, r_win_r[r][c_lsb +: c_w]});
            end
        end

        always_comb begin
            w_sum = '0;
            case (r_kern)
                3'd1: w_sum = w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]
                            + (w_p[0][1] <<< 1) + (w_p[1][1] <<< 2) + (w_p[2][1] <<< 1)
                            + w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2];
                3'd2: w_sum = (w_p[1][1] <<< 2) + w_p[1][1]
                            - w_p[1][0] - w_p[1][2] - w_p[0][1] - w_p[2][1];
                3'd3: w_sum = (w_p[1][1] <<< 3)
                            - w_p[0][0] - w_p[1][0] - w_p[2][0] - w_p[0][1]
                            - w_p[2][1] - w_p[0][2] - w_p[1][2] - w_p[2][2];
                3'd4: w_sum = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
                            - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
                3'd5: w_sum = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
                            - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
                default: w_sum = w_p[1][1];
            endcase
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_acc <= '0;
            end else if (r_vld1) begin
                r_acc <= w_sum;
            end
        end

        always_comb begin
            w_mag = r_acc;
`ifdef CONV_ABS_EN
            if ((r_kern2 == 3'd4 || r_kern2 == 3'd5) && r_acc[c_aw-1]) begin
                w_mag = -r_acc;
            end
`endif
            case (r_kern2)
                3'd1:       w_shf = w_mag >>> 4;
                3'd4, 3'd5: w_shf = w_mag >>> 2;
                default:    w_shf = w_mag;
            endcase
            if (w_shf[c_aw-1]) begin
                w_res = '0;
            end else if (|w_shf[c_aw-2:c_w]) begin
                w_res = '1;
            end else begin
                w_res = w_shf[c_w-1:0];
            end
        end

        assign w_pix[c_lsb +: c_w] = w_res;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_out       <= '0;
            data_valid_out <= 1'b0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            data_valid_out <= r_vld2;
            if (r_vld2) begin
                line_out   <= w_pix;
                hcount_out <= r_hc2;
                vcount_out <= r_vc2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_pipe
// Purpose  : Self-checking bench for conv3x3_pipe (default 5/6/5 pixels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_pipe;

    localparam int N = 4096;
`ifdef CONV_ABS_EN
    localparam logic [15:0] c_step_dn = 16'h4000;
`else
    localparam logic [15:0] c_step_dn = 16'h0000;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][15:0] din;
    logic [10:0]      hin;
    logic [9:0]       vin;
    logic             vld;
    logic [2:0]       ksel;
    logic [15:0]      lout;
    logic             dvo;
    logic [10:0]      hout;
    logic [9:0]       vout;

    always #5 clk = ~clk;

    conv3x3_pipe dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .data_in       (din),
        .hcount_in     (hin),
        .vcount_in     (vin),
        .data_valid_in (vld),
        .kernel_sel_in (ksel),
        .line_out      (lout),
        .data_valid_out(dvo),
        .hcount_out    (hout),
        .vcount_out    (vout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output per posedge index
    bit          exp_v   [N];
    logic [15:0] exp_p   [N];
    logic [10:0] exp_h   [N];
    logic [9:0]  exp_vc  [N];
    bit          rst_at  [N];
    bit          lit_en  [N];
    logic [15:0] lit_val [N];

    logic [15:0] mw [3][3];
    int          mk = 0;
    int          last_slot = 0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mo_p;
    logic [10:0] mo_h;
    logic [9:0]  mo_v;

    // r: 0=top,1=mid,2=bottom; c: 0=left,1=center,2=right
    function automatic int coef(int k, int r, int c);
        case (k)
            1:       return (r == 1 ? 2 : 1) * (c == 1 ? 2 : 1);
            2:       return (r == 1 && c == 1) ? 5 : (((r == 1) != (c == 1)) ? -1 : 0);
            3:       return (r == 1 && c == 1) ? 8 : -1;
            4:       return (c - 1) * (r == 1 ? 2 : 1);
            5:       return (r - 1) * (c == 1 ? 2 : 1);
            default: return (r == 1 && c == 1) ? 1 : 0;
        endcase
    endfunction

    function automatic int kshift(int k);
        if (k == 1) return 4;
        if (k == 4 || k == 5) return 2;
        return 0;
    endfunction

    function automatic logic [15:0] model_pix(int k);
        logic [15:0] res;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int w;
            int lsb;
            int mx;
            int sum;
            w   = (ch == 1) ? 6 : 5;
            lsb = (ch == 0) ? 11 : (ch == 1) ? 5 : 0;
            mx  = (1 << w) - 1;
            sum = 0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    sum += coef(k, r, c) * int'((mw[c][r] >> lsb) & 16'(mx));
`ifdef CONV_ABS_EN
            if ((k == 4 || k == 5) && sum < 0) sum = -sum;
`endif
            sum = sum >>> kshift(k);
            if (sum < 0) sum = 0;
            if (sum > mx) sum = mx;
            res = res | 16'(sum << lsb);
        end
        return res;
    endfunction

    function automatic logic [15:0] pix_of(int pat, int h, int v, int r);
        case (pat)
            0:       return (r == 1) ? 16'hFFE0 : 16'h28A5;
            1:       return 16'h528A;
            2:       return (h < 5) ? 16'h0000 : 16'h4000;
            3:       return (h < 5) ? 16'h4000 : 16'h0000;
            4:       return (h < 5) ? 16'h0000 : 16'hF800;
            5:       return {5'(h + v), 6'(3 * h + r), 5'(v + r)};
            6:       return (((h + v + r) % 2) == 1) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                        input int h, input int v, input logic [2:0] ks);
        rst = 1'b0; vld = 1'b1;
        din[0] = p0; din[1] = p1; din[2] = p2;
        hin = 11'(h); vin = 10'(v); ksel = ks;
        if (h == 0) begin
            for (int c = 0; c < 3; c++) begin
                mw[c][0] = p0; mw[c][1] = p1; mw[c][2] = p2;
            end
        end else begin
            mw[0] = mw[1];
            mw[1] = mw[2];
            mw[2][0] = p0; mw[2][1] = p1; mw[2][2] = p2;
        end
        if (h == 0 && v == 0) mk = int'(ks);
        last_slot = cyc + 3;
        exp_v[last_slot]  = 1'b1;
        exp_p[last_slot]  = model_pix(mk);
        exp_h[last_slot]  = 11'(h);
        exp_vc[last_slot] = 10'(v);
        step();
    endtask

    // Invalid cycle carrying bait values that must not be absorbed
    task automatic idle();
        rst = 1'b0; vld = 1'b0; din = '1; hin = '0; vin = '0; ksel = 3'd7;
        step();
    endtask

    task automatic reset_beat();
        rst = 1'b1; vld = 1'b1;
        rst_at[cyc + 1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_v[cyc + i]   = 1'b0;
            lit_en[cyc + i]  = 1'b1;
            lit_val[cyc + i] = 16'h0000;
        end
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) mw[c][r] = '0;
        mk = 0;
        step();
    endtask

    task automatic pin(input logic [15:0] val);
        lit_en[last_slot]  = 1'b1;
        lit_val[last_slot] = val;
    endtask

    // pin_h: -1 pins every beat, -2 pins none
    task automatic do_row(input int pat, input int v, input logic [2:0] ks, input logic [2:0] ks2,
                          input int gap, input int pin_h, input logic [15:0] pin_val);
        for (int h = 0; h < 10; h++) begin
            if (gap > 0 && h > 0 && (h % gap) == 0) idle();
            beat(pix_of(pat, h, v, 0), pix_of(pat, h, v, 1), pix_of(pat, h, v, 2),
                 h, v, (h >= 5) ? ks2 : ks);
            if (pin_h == -1 || pin_h == h) pin(pin_val);
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, got, req);
        end
    endtask

    always @(negedge clk) begin
        int k;
        k = cyc;
        if (k < N) begin
            if (rst_at[k]) begin
                mo_p = '0; mo_h = '0; mo_v = '0;
                chk_en = 1'b1;
            end else if (exp_v[k]) begin
                mo_p = exp_p[k]; mo_h = exp_h[k]; mo_v = exp_vc[k];
            end
            if (chk_en) begin
                chk("valid", k, 16'(dvo), 16'(exp_v[k]));
                chk("line", k, lout, mo_p);
                chk("hcount", k, 16'(hout), 16'(mo_h));
                chk("vcount", k, 16'(vout), 16'(mo_v));
                if (lit_en[k]) chk("literal", k, lout, lit_val[k]);
            end
        end
    end

    initial begin
        rst = 1'b1; vld = 1'b0; din = '0; hin = '0; vin = '0; ksel = '0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) mw[c][r] = '0;
        reset_beat();
        reset_beat();

        // Identity over constant columns
        for (int v = 0; v < 4; v++) do_row(0, v, 3'd0, 3'd0, 0, -1, 16'hFFE0);
        // Gaussian over a uniform field
        for (int v = 0; v < 2; v++) do_row(1, v, 3'd1, 3'd1, 0, -1, 16'h528A);
        // Sobel-x steps and line-start isolation
        do_row(2, 0, 3'd4, 3'd4, 0, 5, 16'h4000);
        do_row(3, 1, 3'd4, 3'd4, 0, 5, c_step_dn);
        do_row(4, 2, 3'd4, 3'd4, 0, 5, 16'hF800);
        do_row(7, 3, 3'd4, 3'd4, 0, 0, 16'h0000);
        // Mid-frame kernel request with input gaps
        do_row(5, 0, 3'd0, 3'd0, 3, -2, 16'h0000);
        do_row(5, 1, 3'd0, 3'd0, 3, -2, 16'h0000);
        do_row(5, 2, 3'd0, 3'd1, 3, 7, 16'h4263);
        do_row(5, 3, 3'd1, 3'd1, 3, -2, 16'h0000);
        do_row(1, 0, 3'd1, 3'd1, 0, 0, 16'h528A);
        // Remaining kernels, including saturating and negative results
        do_row(6, 0, 3'd2, 3'd2, 0, -2, 16'h0000);
        do_row(6, 1, 3'd2, 3'd2, 0, -2, 16'h0000);
        do_row(5, 0, 3'd3, 3'd3, 0, -2, 16'h0000);
        do_row(5, 1, 3'd3, 3'd3, 0, -2, 16'h0000);
        do_row(6, 0, 3'd3, 3'd3, 0, -2, 16'h0000);
        do_row(5, 0, 3'd5, 3'd5, 0, -2, 16'h0000);
        do_row(5, 1, 3'd5, 3'd5, 0, -2, 16'h0000);
        do_row(6, 0, 3'd5, 3'd5, 0, -2, 16'h0000);
        do_row(5, 0, 3'd4, 3'd4, 0, -2, 16'h0000);
        do_row(6, 1, 3'd4, 3'd4, 0, -2, 16'h0000);
        do_row(5, 0, 3'd7, 3'd7, 0, -2, 16'h0000);
        do_row(6, 0, 3'd6, 3'd6, 0, -2, 16'h0000);
        // Reset pulse in the middle of a continuous stream
        for (int h = 0; h < 5; h++)
            beat(pix_of(5, h, 0, 0), pix_of(5, h, 0, 1), pix_of(5, h, 0, 2), h, 0, 3'd0);
        reset_beat();
        for (int h = 5; h < 10; h++) begin
            beat(pix_of(5, h, 0, 0), pix_of(5, h, 0, 1), pix_of(5, h, 0, 2), h, 0, 3'd0);
            if (h == 5) pin(16'h0000);
            if (h == 6) pin(16'h2A01);
        end
        for (int i = 0; i < 6; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
